// File: rtl/ifetch_unit.sv
// In-order instruction fetch: owns the PC, issues single-word reads and buffers words for the instruction queue.
// Define IFETCH_SKID_EN for a two-entry output buffer; otherwise the buffer holds a single entry.
module ifetch_unit #(
    parameter int unsigned      width    = 32,
    parameter logic [width-1:0] reset_pc = width'(32'h0000_0060)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_read,
    output logic [width-1:0] mem_address,
    input  logic             mem_resp,
    input  logic [width-1:0] mem_rdata,
    input  logic             iq_full,
    output logic             iq_enq,
    output logic [width-1:0] iq_instr,
    output logic [width-1:0] iq_pc,
    input  logic             redirect,
    input  logic [width-1:0] redirect_pc
);

`ifdef IFETCH_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    typedef struct packed {
        logic [width-1:0] instr;
        logic [width-1:0] pc;
    } entry_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] pc;
    logic [width-1:0] pc_nxt;
    logic [width-1:0] addr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             deq;
    logic             wr;
    entry_t           head;
`ifdef IFETCH_SKID_EN
    logic [OCC_W-1:0] wr_idx;
    entry_t           skid;
`endif

    // Buffer push/pop decisions and next PC; redirect suppresses both push and pop.
    always_comb begin
        deq     = (occ != '0) && !iq_full && !redirect;
        wr      = (state == REQ) && mem_resp && !redirect;
        occ_nxt = occ + OCC_W'(wr) - OCC_W'(deq);
        pc_nxt  = redirect ? redirect_pc : (wr ? pc + width'(4) : pc);
`ifdef IFETCH_SKID_EN
        wr_idx  = occ - OCC_W'(deq);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect)      state_nxt = mem_resp ? REQ : DROP;
                else if (mem_resp) state_nxt = (occ_nxt < OCC_W'(DEPTH)) ? REQ : WAIT;
            end
            WAIT: if (redirect || (occ_nxt < OCC_W'(DEPTH))) state_nxt = REQ;
            // An issued read cannot be cancelled; wait out its response.
            DROP: if (mem_resp) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Address tracks the PC except while a stale read is still owed a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= reset_pc;
            addr <= reset_pc;
            occ  <= '0;
            head <= '0;
`ifdef IFETCH_SKID_EN
            skid <= '0;
`endif
        end else begin
            pc   <= pc_nxt;
            addr <= (state_nxt == DROP) ? addr : pc_nxt;
            occ  <= redirect ? '0 : occ_nxt;
`ifdef IFETCH_SKID_EN
            if (deq) head <= skid;
            if (wr && (wr_idx == OCC_W'(0))) head <= {mem_rdata, pc};
            if (wr && (wr_idx == OCC_W'(1))) skid <= {mem_rdata, pc};
`else
            if (wr) head <= {mem_rdata, pc};
`endif
        end
    end

    always_comb begin
        mem_read    = (state == REQ) || (state == DROP);
        mem_address = addr;
        iq_enq      = deq;
        iq_instr    = head.instr;
        iq_pc       = head.pc;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a behavioural memory answers reads, expected {instr, pc} pairs are queued per response.
module tb_ifetch_unit;

    localparam int unsigned W = 32;
`ifdef IFETCH_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic [W-1:0] mem_address;
    logic         mem_resp;
    logic [W-1:0] mem_rdata;
    logic         iq_full;
    logic         iq_enq;
    logic [W-1:0] iq_instr;
    logic [W-1:0] iq_pc;
    logic         redirect;
    logic [W-1:0] redirect_pc;

    ifetch_unit #(.width(W), .reset_pc(32'h0000_0060)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .iq_full     (iq_full),
        .iq_enq      (iq_enq),
        .iq_instr    (iq_instr),
        .iq_pc       (iq_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    bit          pending;
    bit          stale;
    bit          full_knob;
    bit          saw_read;
    bit          found;
    int          cnt;
    int          lat;
    logic [31:0] req_addr;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: memory model answers, inputs driven, outputs checked, scoreboard updated.
    task automatic cycle(input bit rd, input logic [31:0] rpc);
        bit   resp;
        bit   exp_enq;
        exp_t e;
        @(posedge clk);
        #1;
        resp = 1'b0;
        if (mem_read) saw_read = 1'b1;
        if (mem_read && !pending) begin
            check("fetch_addr", mem_address, exp_fetch);
            pending  = 1'b1;
            req_addr = mem_address;
            cnt      = lat;
        end else if (pending) begin
            check("hold_read", 32'(mem_read), 32'd1);
            check("hold_addr", mem_address, req_addr);
        end
        if (pending) begin
            if (cnt == 0) resp = 1'b1;
            else          cnt--;
        end
        mem_resp    = resp;
        mem_rdata   = resp ? word_of(req_addr) : $urandom;
        redirect    = rd;
        redirect_pc = rd ? rpc : $urandom;
        iq_full     = full_knob;
        #1;
        exp_enq = (sb.size() != 0) && !full_knob && !rd;
        check("iq_enq", 32'(iq_enq), 32'(exp_enq));
        if (iq_enq && exp_enq) begin
            e = sb.pop_front();
            check("iq_pc", iq_pc, e.pc);
            check("iq_instr", iq_instr, e.instr);
        end
        if (rd) begin
            sb.delete();
            exp_fetch = rpc;
            if (pending) begin
                if (resp) begin
                    pending = 1'b0;
                    stale   = 1'b0;
                end else begin
                    stale = 1'b1;
                end
            end
        end else if (resp) begin
            pending = 1'b0;
            if (stale) begin
                stale = 1'b0;
            end else begin
                sb.push_back({word_of(req_addr), req_addr});
                exp_fetch = req_addr + 32'd4;
            end
        end
    endtask

    // Assert reset (asynchronously), hold, then release just after an edge with an optional late response.
    task automatic do_reset(input bit late_resp);
        rst = 1'b0;
        #1;
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_enq", 32'(iq_enq), 32'd0);
        sb.delete();
        pending     = 1'b0;
        stale       = 1'b0;
        exp_fetch   = 32'h60;
        full_knob   = 1'b0;
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        iq_full     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", mem_address, 32'h60);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_resp  = late_resp;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("idle_read", 32'(mem_read), 32'd0);
        check("idle_enq", 32'(iq_enq), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        iq_full     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = 1;
        full_knob   = 1'b0;
        pending     = 1'b0;
        stale       = 1'b0;
        exp_fetch   = 32'h60;
        #2;
        do_reset(1'b0);
        saw_read = 1'b0;
        cycle(1'b0, '0);
        check("first_read", 32'(saw_read), 32'd1);

        // Streaming with a one-cycle memory.
        repeat (20) cycle(1'b0, '0);

        // Queue backpressure fills the buffer and stops fetching.
        full_knob = 1'b1;
        repeat (10) cycle(1'b0, '0);
        check("bp_occ", 32'(sb.size()), 32'(DEPTH));
        check("bp_read", 32'(mem_read), 32'd0);
        full_knob = 1'b0;
        repeat (15) cycle(1'b0, '0);

        // Redirect while the read to 0x64 is outstanding.
        do_reset(1'b0);
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            if (pending && req_addr == 32'h64) found = 1'b1;
        end
        check("t3_reach", 32'(found), 32'd1);
        cycle(1'b1, 32'h200);
        repeat (15) cycle(1'b0, '0);

        // Redirect coinciding with a response while the queue is stalled.
        lat   = 2;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            full_knob = (DEPTH > 1) && (sb.size() != 0);
            cycle(1'b0, '0);
            if (pending && cnt == 0 && sb.size() == DEPTH - 1) found = 1'b1;
        end
        check("t4_reach", 32'(found), 32'd1);
        full_knob = 1'b1;
        cycle(1'b1, 32'h500);
        full_knob = 1'b0;
        cycle(1'b0, '0);
        check("t4_addr", req_addr, 32'h500);
        repeat (10) cycle(1'b0, '0);

        // Two redirects while draining a stale read; the last one wins.
        lat   = 4;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            if (pending && cnt == 3) found = 1'b1;
        end
        check("t5_reach", 32'(found), 32'd1);
        cycle(1'b1, 32'h300);
        cycle(1'b0, '0);
        cycle(1'b1, 32'h400);
        repeat (2) cycle(1'b0, '0);
        check("t5_addr", req_addr, 32'h400);
        check("t5_pend", 32'(pending), 32'd1);
        repeat (10) cycle(1'b0, '0);

        // Reset in the middle of a request, with a late response after release.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            if (pending) found = 1'b1;
        end
        check("t6_reach", 32'(found), 32'd1);
        do_reset(1'b1);
        lat      = 1;
        saw_read = 1'b0;
        cycle(1'b0, '0);
        check("t6_read", 32'(saw_read), 32'd1);
        repeat (10) cycle(1'b0, '0);

        // Mixed random latency, backpressure and redirects.
        for (int i = 0; i < 400; i++) begin
            lat       = $urandom_range(0, 3);
            full_knob = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) cycle(1'b1, 32'($urandom_range(0, 1023)) << 2);
            else                            cycle(1'b0, '0);
        end
        full_knob = 1'b0;
        lat       = 1;
        repeat (10) cycle(1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
